// File: rtl/infer_pkg.sv
// Shared types and constants for the inference-engine sequencing controller.
package infer_pkg;

  localparam int unsigned N_IN_DEF    = 400;
  localparam int unsigned N_HID_DEF   = 20;
  localparam int unsigned N_OUT_DEF   = 10;
  localparam int unsigned TIMEOUT_DEF = 65535;

  localparam int unsigned W12_DEPTH  = N_IN_DEF * N_HID_DEF;
  localparam int unsigned B12_DEPTH  = N_HID_DEF;
  localparam int unsigned W23_DEPTH  = N_HID_DEF * N_OUT_DEF;
  localparam int unsigned B23_DEPTH  = N_OUT_DEF;
  localparam int unsigned DATA_DEPTH = N_IN_DEF;

  localparam int unsigned AW_W12  = 13;
  localparam int unsigned AW_B12  = 5;
  localparam int unsigned AW_DATA = 9;
  localparam int unsigned AW_W23  = 8;
  localparam int unsigned AW_B23  = 4;
  localparam int unsigned CNT_W   = AW_W12;
  localparam int unsigned DW      = 16;
  localparam int unsigned PW      = 2;
  localparam int unsigned OH_W    = 10;
  localparam int unsigned CLS_W   = 4;
  localparam int unsigned TW      = 16;
  localparam int unsigned NMEM    = 5;

  typedef enum logic [3:0] {
    IDLE, LD_W12, LD_B12, LD_W23, LD_B23, LD_DATA, START, WAIT, RESULT
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK         = 2'd0,
    ERR_ONEHOT     = 2'd1,
    ERR_TIMEOUT    = 2'd2,
    ERR_NO_WEIGHTS = 2'd3
  } res_err_t;

  typedef struct packed {
    logic [OH_W-1:0]  onehot;
    logic [CLS_W-1:0] cls;
    res_err_t         err;
  } result_t;

  localparam result_t RES_RST = '{onehot: '0, cls: '1, err: ERR_OK};

endpackage

// File: rtl/onehot_dec.sv
// One-hot to class index decoder; index is all-ones unless exactly one bit is set.
module onehot_dec
  import infer_pkg::*;
(
  input  logic [OH_W-1:0]  onehot,
  output logic [CLS_W-1:0] class_idx,
  output logic             valid
);

  logic [CLS_W-1:0] ones;
  logic [CLS_W-1:0] pos;

  always_comb begin
    ones = '0;
    pos  = '0;
    for (int unsigned i = 0; i < OH_W; i++) begin
      if (onehot[i]) begin
        ones = ones + CLS_W'(1);
        pos  = CLS_W'(i);
      end
    end
    valid     = (ones == CLS_W'(1));
    class_idx = valid ? pos : '1;
  end

endmodule

// File: rtl/infer_seq_ctrl.sv
// Loads engine memories from a word stream, starts the engine, and returns the
// decoded result over a valid/ready port.
module infer_seq_ctrl
  import infer_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEF,
  parameter int unsigned N_HID   = N_HID_DEF,
  parameter int unsigned N_OUT   = N_OUT_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_weights,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  output logic [DW-1:0]      w12_wrdata,
  output logic [DW-1:0]      b12_wrdata,
  output logic [DW-1:0]      w23_wrdata,
  output logic [DW-1:0]      b23_wrdata,
  output logic [PW-1:0]      wrdata,
  output logic [AW_W12-1:0]  wr_w12addr,
  output logic [AW_B12-1:0]  wr_b12addr,
  output logic [AW_DATA-1:0] wraddr,
  output logic [AW_W23-1:0]  wr_w23addr,
  output logic [AW_B23-1:0]  wr_b23addr,
  output logic               we,
  output logic               we_b12,
  output logic               w23_we,
  output logic               b23_we,
  output logic               we_data,
  output logic               rd,
  output logic               rd_b12,
  output logic               w23_rd,
  output logic               b23_rd,
  output logic               rd_data,
  output logic               start,
  input  logic               done,
  input  logic [OH_W-1:0]    onehot_enc,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [OH_W-1:0]    res_onehot,
  output logic [CLS_W-1:0]   res_class,
  output logic [1:0]         res_err,
  output logic               busy,
  output logic               weights_loaded
);

  localparam int unsigned W12_LAST  = N_IN * N_HID - 1;
  localparam int unsigned B12_LAST  = N_HID - 1;
  localparam int unsigned W23_LAST  = N_HID * N_OUT - 1;
  localparam int unsigned B23_LAST  = N_OUT - 1;
  localparam int unsigned DATA_LAST = N_IN - 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              wl_d;
  logic [NMEM-1:0]   wstb_q, wstb_d;
  logic [CNT_W-1:0]  waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              start_d, rv_d, rd_q;
  result_t           res_q, res_d;
  logic              beat_c, last_c;
  logic [CLS_W-1:0]  dec_idx;
  logic              dec_valid;

  onehot_dec u_dec (
    .onehot    (onehot_enc),
    .class_idx (dec_idx),
    .valid     (dec_valid)
  );

  assign beat_c = s_valid && s_ready;

  // Last address of the memory currently being loaded
  always_comb begin
    last_c = 1'b0;
    case (state_q)
      LD_W12:  last_c = (cnt_q == CNT_W'(W12_LAST));
      LD_B12:  last_c = (cnt_q == CNT_W'(B12_LAST));
      LD_W23:  last_c = (cnt_q == CNT_W'(W23_LAST));
      LD_B23:  last_c = (cnt_q == CNT_W'(B23_LAST));
      LD_DATA: last_c = (cnt_q == CNT_W'(DATA_LAST));
      default: last_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    wl_d    = weights_loaded;
    wstb_d  = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    start_d = 1'b0;
    rv_d    = res_valid;
    res_d   = res_q;

    if (beat_c) begin
      waddr_d = cnt_q;
      wdata_d = s_data;
      cnt_d   = last_c ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_weights) begin
            state_d = LD_W12;
            wl_d    = 1'b0;
          end else if (weights_loaded) begin
            state_d = LD_DATA;
          end else begin
            state_d = RESULT;
            rv_d    = 1'b1;
            res_d   = '{onehot: '0, cls: '1, err: ERR_NO_WEIGHTS};
          end
        end
      end
      LD_W12: if (beat_c) begin
        wstb_d[0] = 1'b1;
        if (last_c) state_d = LD_B12;
      end
      LD_B12: if (beat_c) begin
        wstb_d[1] = 1'b1;
        if (last_c) state_d = LD_W23;
      end
      LD_W23: if (beat_c) begin
        wstb_d[2] = 1'b1;
        if (last_c) state_d = LD_B23;
      end
      LD_B23: if (beat_c) begin
        wstb_d[3] = 1'b1;
        if (last_c) begin
          state_d = LD_DATA;
          wl_d    = 1'b1;
        end
      end
      LD_DATA: if (beat_c) begin
        wstb_d[4] = 1'b1;
        if (last_c) state_d = START;
      end
      START: begin
        start_d = 1'b1;
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done) begin
          state_d    = RESULT;
          rv_d       = 1'b1;
          res_d.onehot = onehot_enc;
          res_d.cls    = dec_idx;
          res_d.err    = dec_valid ? ERR_OK : ERR_ONEHOT;
        end else if (tcnt_q == TW'(TIMEOUT)) begin
          state_d = RESULT;
          rv_d    = 1'b1;
          res_d   = '{onehot: '0, cls: '1, err: ERR_TIMEOUT};
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      RESULT: begin
        if (res_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tcnt_q         <= '0;
      weights_loaded <= 1'b0;
      wstb_q         <= '0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      start          <= 1'b0;
      res_valid      <= 1'b0;
      res_q          <= RES_RST;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      s_ready        <= 1'b0;
      rd_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tcnt_q         <= tcnt_d;
      weights_loaded <= wl_d;
      wstb_q         <= wstb_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      start          <= start_d;
      res_valid      <= rv_d;
      res_q          <= res_d;
      cmd_ready      <= (state_d == IDLE);
      busy           <= (state_d != IDLE);
      s_ready        <= (state_d inside {LD_W12, LD_B12, LD_W23, LD_B23, LD_DATA});
      rd_q           <= (state_d == WAIT);
    end
  end

  // One shared address/data pipeline; the strobe selects the target memory
  assign {we_data, b23_we, w23_we, we_b12, we} = wstb_q;
  assign wr_w12addr = waddr_q;
  assign wr_b12addr = waddr_q[AW_B12-1:0];
  assign wr_w23addr = waddr_q[AW_W23-1:0];
  assign wr_b23addr = waddr_q[AW_B23-1:0];
  assign wraddr     = waddr_q[AW_DATA-1:0];
  assign w12_wrdata = wdata_q;
  assign b12_wrdata = wdata_q;
  assign w23_wrdata = wdata_q;
  assign b23_wrdata = wdata_q;
  assign wrdata     = wdata_q[PW-1:0];
  assign {rd, rd_b12, w23_rd, b23_rd, rd_data} = {5{rd_q}};
  assign res_onehot = res_q.onehot;
  assign res_class  = res_q.cls;
  assign res_err    = res_q.err;

endmodule

// File: tb/tb_infer_seq_ctrl.sv
// Bench for infer_seq_ctrl: stream driver, engine stub, write scoreboard.
module tb_infer_seq_ctrl;

  localparam int TO = 100;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready, cmd_weights;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic [15:0] w12_wrdata, b12_wrdata, w23_wrdata, b23_wrdata;
  logic [1:0]  wrdata;
  logic [12:0] wr_w12addr;
  logic [4:0]  wr_b12addr;
  logic [8:0]  wraddr;
  logic [7:0]  wr_w23addr;
  logic [3:0]  wr_b23addr;
  logic        we, we_b12, w23_we, b23_we, we_data;
  logic        rd, rd_b12, w23_rd, b23_rd, rd_data;
  logic        start, done;
  logic [9:0]  onehot_enc;
  logic        res_valid, res_ready;
  logic [9:0]  res_onehot;
  logic [3:0]  res_class;
  logic [1:0]  res_err;
  logic        busy, weights_loaded;

  infer_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_weights(cmd_weights),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .w12_wrdata(w12_wrdata), .b12_wrdata(b12_wrdata),
    .w23_wrdata(w23_wrdata), .b23_wrdata(b23_wrdata), .wrdata(wrdata),
    .wr_w12addr(wr_w12addr), .wr_b12addr(wr_b12addr), .wraddr(wraddr),
    .wr_w23addr(wr_w23addr), .wr_b23addr(wr_b23addr),
    .we(we), .we_b12(we_b12), .w23_we(w23_we), .b23_we(b23_we), .we_data(we_data),
    .rd(rd), .rd_b12(rd_b12), .w23_rd(w23_rd), .b23_rd(b23_rd), .rd_data(rd_data),
    .start(start), .done(done), .onehot_enc(onehot_enc),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_onehot(res_onehot), .res_class(res_class), .res_err(res_err),
    .busy(busy), .weights_loaded(weights_loaded)
  );

  typedef struct { int m; int a; int d; int c; } wr_t;
  wr_t exp_q[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int exp_start = -1;
  int n_start = 0;
  int cnt_mem[5];
  bit chk_en = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pat(input int g);
    return 16'((g * 37 + 11) ^ (g >> 3));
  endfunction

  // Global beat index of a full load -> (memory, address)
  function automatic void map_beat(input int g, output int m, output int a);
    if (g < 8000)      begin m = 0; a = g;        end
    else if (g < 8020) begin m = 1; a = g - 8000; end
    else if (g < 8220) begin m = 2; a = g - 8020; end
    else if (g < 8230) begin m = 3; a = g - 8220; end
    else               begin m = 4; a = g - 8230; end
  endfunction

  // Scoreboard: every strobe must match the next expected write, one cycle after acceptance
  int  ns, am, aa, ad;
  wr_t e;
  always @(negedge clk) begin
    if (chk_en) begin
      ns = int'(we) + int'(we_b12) + int'(w23_we) + int'(b23_we) + int'(we_data);
      if (ns > 1) check("single_strobe", ns, 1);
      else if (ns == 1) begin
        if (we)          begin am = 0; aa = int'(wr_w12addr); ad = int'(w12_wrdata); end
        else if (we_b12) begin am = 1; aa = int'(wr_b12addr); ad = int'(b12_wrdata); end
        else if (w23_we) begin am = 2; aa = int'(wr_w23addr); ad = int'(w23_wrdata); end
        else if (b23_we) begin am = 3; aa = int'(wr_b23addr); ad = int'(b23_wrdata); end
        else             begin am = 4; aa = int'(wraddr);     ad = int'(wrdata);     end
        if (exp_q.size() == 0) check("unexpected_write_mem", am, 99);
        else begin
          e = exp_q.pop_front();
          check("wr_mem", am, e.m);
          check("wr_addr", aa, e.a);
          check("wr_data", ad, e.d);
          check("wr_cycle", cyc, e.c);
        end
        cnt_mem[am]++;
      end
      if (start) begin
        n_start++;
        check("start_cycle", cyc, exp_start);
      end
    end
  end

  task automatic issue_cmd(input bit w, output int c);
    bit acc;
    @(posedge clk); #1;
    cmd_weights = w;
    cmd_valid   = 1;
    acc = 0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1;
      else begin @(posedge clk); #1; end
    end
    if (!acc) check("cmd_accept", 0, 1);
    c = cyc;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic stream(input int base, input int n, input bit gaps, output int last_acc);
    bit acc;
    int g, w, m, a;
    last_acc = -1;
    for (int i = 0; i < n; i++) begin
      g = base + i;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_valid = 1;
      s_data  = pat(g);
      acc = 0;
      w   = 0;
      while (!acc && w < 50) begin
        @(negedge clk);
        if (s_ready) acc = 1;
        else begin @(posedge clk); #1; w++; end
      end
      if (!acc) begin
        check("s_ready_wait", 0, 1);
        s_valid = 0;
        return;
      end
      map_beat(g, m, a);
      exp_q.push_back('{m: m, a: a, d: (m == 4) ? int'(pat(g) & 16'h3) : int'(pat(g)), c: cyc + 1});
      last_acc = cyc;
      @(posedge clk); #1;
    end
    s_valid = 0;
  endtask

  task automatic run_image(input bit wts, input bit gaps, input bit respond,
                           input logic [9:0] eng, input logic [3:0] ecls,
                           input logic [1:0] eerr, input logic [9:0] eoh, input int hold);
    int c, la, s;
    bit seen;
    for (int k = 0; k < 5; k++) cnt_mem[k] = 0;
    n_start   = 0;
    res_ready = (hold == 0);
    issue_cmd(wts, c);
    stream(wts ? 0 : 8230, wts ? 8630 : 400, gaps, la);
    exp_start = la + 2;
    seen = 0;
    s    = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (start) begin seen = 1; s = cyc; end
    end
    if (!seen) begin
      check("start_seen", 0, 1);
      exp_start = -1;
      return;
    end
    check("rd_in_wait", {rd, rd_b12, w23_rd, b23_rd, rd_data}, 5'b11111);
    check("weights_loaded_run", weights_loaded, 1);
    if (respond) begin
      repeat (50) @(posedge clk);
      #1 done = 1; onehot_enc = eng;
      @(negedge clk); check("res_early", res_valid, 0);
      @(posedge clk); #1 done = 0;
    end else begin
      repeat (TO) @(posedge clk);
      @(negedge clk); check("res_early", res_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    check("res_valid", res_valid, 1);
    check("res_onehot", res_onehot, eoh);
    check("res_class", res_class, ecls);
    check("res_err", res_err, eerr);
    check("rd_after", rd, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("res_hold_valid", res_valid, 1);
      check("res_hold_class", res_class, ecls);
      check("res_hold_err", res_err, eerr);
    end
    res_ready = 1;
    @(negedge clk);
    check("res_valid_drop", res_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
    check("busy_back", busy, 0);
    check("cnt_w12",  cnt_mem[0], wts ? 8000 : 0);
    check("cnt_b12",  cnt_mem[1], wts ? 20 : 0);
    check("cnt_w23",  cnt_mem[2], wts ? 200 : 0);
    check("cnt_b23",  cnt_mem[3], wts ? 10 : 0);
    check("cnt_data", cnt_mem[4], 400);
    check("n_start",  n_start, 1);
    check("queue_drained", exp_q.size(), 0);
    exp_start  = -1;
    onehot_enc = '0;
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_class"}, res_class, 4'hF);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_res_onehot"}, res_onehot, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_weights_loaded"}, weights_loaded, 0);
    check({tag, "_strobes"}, {we, we_b12, w23_we, b23_we, we_data}, 0);
    check({tag, "_rd"}, {rd, rd_b12, w23_rd, b23_rd, rd_data}, 0);
    check({tag, "_w12addr"}, wr_w12addr, 0);
    check({tag, "_w12data"}, w12_wrdata, 0);
  endtask

  int c0, la0;

  initial begin
    reset = 0; cmd_valid = 0; cmd_weights = 0; s_valid = 0; s_data = '0;
    done = 0; onehot_enc = '0; res_ready = 0;
    repeat (3) @(negedge clk);
    reset_values("rst");
    reset = 1;
    chk_en = 1;

    // Image without weights after reset
    for (int k = 0; k < 5; k++) cnt_mem[k] = 0;
    n_start   = 0;
    res_ready = 1;
    issue_cmd(0, c0);
    @(negedge clk);
    check("nw_res_valid", res_valid, 1);
    check("nw_res_err", res_err, 3);
    check("nw_res_onehot", res_onehot, 0);
    check("nw_res_class", res_class, 4'hF);
    check("nw_s_ready", s_ready, 0);
    @(negedge clk);
    check("nw_res_drop", res_valid, 0);
    check("nw_cmd_ready", cmd_ready, 1);
    repeat (5) @(negedge clk);
    check("nw_n_start", n_start, 0);
    check("nw_writes", cnt_mem[0] + cnt_mem[1] + cnt_mem[2] + cnt_mem[3] + cnt_mem[4], 0);

    run_image(1, 0, 1, 10'b0000001000, 4'd3, 2'd0, 10'b0000001000, 0);
    run_image(0, 1, 1, 10'b1000000000, 4'd9, 2'd0, 10'b1000000000, 0);
    run_image(0, 1, 1, 10'b0000100100, 4'hF, 2'd1, 10'b0000100100, 3);
    run_image(0, 0, 0, 10'b0000000000, 4'hF, 2'd2, 10'b0000000000, 0);

    // Reset in the middle of the w12 load
    issue_cmd(1, c0);
    stream(0, 3000, 0, la0);
    check("mid_busy", busy, 1);
    check("mid_cmd_ready", cmd_ready, 0);
    check("mid_weights_loaded", weights_loaded, 0);
    check("mid_we", we, 1);
    check("mid_w12addr", wr_w12addr, 2999);
    #1;
    chk_en = 0;
    reset  = 0;
    #1;
    reset_values("midrst");
    exp_q.delete();
    @(negedge clk);
    reset  = 1;
    chk_en = 1;
    run_image(1, 0, 1, 10'b0000000001, 4'd0, 2'd0, 10'b0000000001, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/infer_seq_ctrl.md
# infer_seq_ctrl

Sequencing controller for the digit-recognition inference engine top level. It accepts a command and a 16-bit word stream. It loads the five engine memories (w12, b12, w23, b23, pixel data) through their write ports in a fixed order, pulses `start`, and waits for `done` with a timeout. It then returns the one-hot result, together with a decoded class index, over a valid/ready result port.

## Interface
- `N_IN`, 400: pixels per image; data memory depth, addresses 0..N_IN-1.
- `N_HID`, 20: hidden nodes; b12 depth. w12 depth is N_IN*N_HID = 8000.
- `N_OUT`, 10: output classes; b23 depth. w23 depth is N_HID*N_OUT = 200.
- `TIMEOUT`, 65535: maximum cycles from `start` to `done`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `cmd_valid`/`cmd_ready` in/out 1: command handshake.
- `cmd_weights` in 1: 1 = weight+bias load, then image; 0 = image only.
- `s_valid`/`s_ready` in/out 1: stream handshake.
- `s_data` in 16: Q6.10 word; for pixels only `[1:0]` is used.
- `w12_wrdata`, `b12_wrdata`, `w23_wrdata`, `b23_wrdata` out 16 each: memory write data.
- `wrdata` out 2: pixel write data.
- `wr_w12addr` (13), `wr_b12addr` (5), `wraddr` (9), `wr_w23addr` (8), `wr_b23addr` (4) out: memory write addresses.
- `we`, `we_b12`, `w23_we`, `b23_we`, `we_data` out 1: write strobes.
- `rd`, `rd_b12`, `w23_rd`, `b23_rd`, `rd_data` out 1: read enables.
- `start` out 1: engine start pulse.
- `done` in 1: engine completion.
- `onehot_enc` in 10: engine result.
- `res_valid`/`res_ready` out/in 1: result handshake.
- `res_onehot` out 10: captured one-hot result.
- `res_class` out 4: decoded class index.
- `res_err` out 2: 0 ok, 1 one-hot invalid, 2 timeout, 3 no weights.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `weights_loaded` out 1: set after a complete weight load.

## Operation
- FSM states: IDLE, LD_W12, LD_B12, LD_W23, LD_B23, LD_DATA, START, WAIT, RESULT.
- IDLE
  - `cmd_ready` = 1.
  - Command accepted with `cmd_weights` = 1 → LD_W12.
  - Command accepted with `cmd_weights` = 0 and `weights_loaded` = 1 → LD_DATA.
  - Command accepted with `cmd_weights` = 0 and `weights_loaded` = 0 → RESULT with `res_err` = 3 and no memory writes.
- LD_* states
  - `s_ready` = 1; one write per accepted beat.
  - Address counter starts at 0 and increments per beat.
  - After the final beat of each memory, the counter clears and the FSM moves to the next load state.
  - Order: w12 (8000 beats) → b12 (20) → w23 (200) → b23 (10) → data (400).
  - `weights_loaded` is cleared on entering LD_W12 and set on leaving LD_B23.
- START: `start` = 1 for exactly one cycle; read enables rise; timeout counter clears.
- WAIT
  - Read enables stay high.
  - `done` = 1 → capture `onehot_enc` and go to RESULT.
  - Timeout counter reaching TIMEOUT → go to RESULT with `res_err` = 2 and `res_onehot` = 0.
- RESULT
  - `res_valid` = 1; all `res_*` outputs are stable.
  - On `res_ready` the FSM returns to IDLE.
  - `res_class` = index of the set bit; 0xF if not exactly one bit is set.
  - `res_err` = 1 if not exactly one bit is set (unless a higher-priority error applies).
- `s_data` is ignored and `s_ready` = 0 outside the LD_* states.

## Timing
- Reset values: all outputs 0 except `cmd_ready` = 1; `res_class` = 0xF; state = IDLE; `weights_loaded` = 0.
- Write pipeline: a beat accepted in cycle t produces strobe, address and data registered and valid in cycle t+1, high for one cycle.
- Stream stalls (`s_valid` = 0) produce no strobe; counters hold.
- The final data write occurs in cycle t+1; START is in cycle t+2; `start` is therefore high at t+2.
- `done` sampled in cycle d gives `res_valid` = 1 at d+1.
- The START→WAIT path ignores `done` in the START cycle itself.
- `res_ready` already high when `res_valid` rises gives a one-cycle RESULT, then IDLE. `cmd_ready` = 1 the cycle after.
- `cmd_valid` arriving during `busy` is not accepted; it must be held.
- Reset asserted mid-operation: immediate return to IDLE; all strobes drop asynchronously; `weights_loaded` cleared; partial loads discarded.
- Address counters never exceed depth-1; wrap is by explicit clear at the last beat, never by overflow.

## Structure
- Package `infer_pkg`:
  - state enum.
  - N_IN/N_HID/N_OUT defaults.
  - Memory depth constants.
  - Address widths (13/5/9/8/4).
  - `res_err` encodings.
- One sub-module, `onehot_dec`: 10-bit one-hot to 4-bit index plus `valid` flag; purely combinational.

## Test plan
- Full load plus image:
  - Stimulus: `cmd_weights` = 1; 8630 beats with no stalls; engine model asserts `done` 50 cycles after `start` with `onehot_enc` = 10'b0000001000.
  - Required: strobe and address counts per memory are exactly 8000/20/200/10/400; `res_class` = 3; `res_err` = 0.
- Image only after load:
  - Stimulus: 400 pixel beats with random `s_valid` gaps.
  - Required: `we_data` count = 400; `wraddr` sequence 0..399; `start` exactly 2 cycles after the last accepted beat.
- Image only with no weights loaded after reset:
  - Required: `res_valid` with `res_err` = 3; zero write strobes; `start` never asserted.
- Timeout:
  - Stimulus: `done` never asserted; TIMEOUT set to 100 for the test.
  - Required: `res_err` = 2 and `res_onehot` = 0.
- Invalid one-hot:
  - Stimulus: engine returns 10'b0000100100.
  - Required: `res_err` = 1; `res_class` = 0xF.
- Reset mid-LD_W12 at beat 3000:
  - Required: all outputs return to reset values within the same cycle; `weights_loaded` = 0; a following full load succeeds from address 0.
